// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for the VGA display path.
// It produces the pixel column/line coordinates, sync, active-video, and
// line/frame strobes. Every output is registered and paced by pix_ce.
// Optional feature: define VGA_FRAME_COUNT_EN to build the 10-bit frame
// counter. When it is undefined, frame_count is tied to zero.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 48,
  parameter int   H_SYNC   = 112,
  parameter int   H_BP     = 248,
  parameter int   V_ACTIVE = 1024,
  parameter int   V_FP     = 1,
  parameter int   V_SYNC   = 3,
  parameter int   V_BP     = 38,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        clk_vga,
  input  logic        reset,
  input  logic        pix_ce,
  output logic [11:0] VGA_HORZ_COORD,
  output logic [11:0] VGA_VERT_COORD,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_ACTIVE,
  output logic        line_start,
  output logic        frame_start,
  output logic [9:0]  frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // The coordinates are 12 bits wide, so neither total may exceed 4096.
  if (H_TOTAL > 4096 || V_TOTAL > 4096 || H_TOTAL < 1 || V_TOTAL < 1) begin : g_bad_totals
    $error("vga_timing_gen: H_TOTAL/V_TOTAL must be in 1..4096");
  end

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

  // The thresholds are 13 bits wide, so that a sync end of exactly 4096
  // still compares correctly against a zero-extended coordinate.
  localparam logic [12:0] H_ACT_END    = 13'(H_ACTIVE);
  localparam logic [12:0] H_SYNC_START = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] H_SYNC_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_ACT_END    = 13'(V_ACTIVE);
  localparam logic [12:0] V_SYNC_START = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] V_SYNC_END   = 13'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h_q, h_d;
  logic [11:0] v_q, v_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        active_q, active_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic        h_wrap, frame_wrap;
  logic [12:0] h_ext, v_ext;

  // Next counter values. The qualifiers are derived from the *next*
  // coordinates, so they change on the same edge as the coordinates.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    h_d           = h_q;
    v_d           = v_q;
    h_wrap        = pix_ce && (h_q == H_LAST);
    frame_wrap    = h_wrap && (v_q == V_LAST);
    line_start_d  = h_wrap;
    frame_start_d = frame_wrap;

    if (pix_ce) begin
      h_d = h_wrap ? 12'd0 : h_q + 12'd1;
    end
    if (h_wrap) begin
      v_d = frame_wrap ? 12'd0 : v_q + 12'd1;
    end

    h_ext    = {1'b0, h_d};
    v_ext    = {1'b0, v_d};
    hs_d     = (h_ext >= H_SYNC_START && h_ext < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    vs_d     = (v_ext >= V_SYNC_START && v_ext < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    active_d = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
  end

  // Timing state register; reset takes priority over pix_ce.
  always_ff @(posedge clk_vga) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      h_q           <= '0;
      v_q           <= '0;
      hs_q          <= ~SYNC_POL;
      vs_q          <= ~SYNC_POL;
      active_q      <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [9:0] frame_count_q, frame_count_d;

  // Frames since reset. The count advances on the frame-wrap edge and wraps modulo 1024.
  always_comb begin
    frame_count_d = frame_count_q + {9'd0, frame_wrap};
  end

  // Frame counter register.
  always_ff @(posedge clk_vga) begin
    if (reset) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`else
  assign frame_count = 10'd0;
`endif

  assign VGA_HORZ_COORD = h_q;
  assign VGA_VERT_COORD = v_q;
  assign VGA_HS         = hs_q;
  assign VGA_VS         = vs_q;
  assign VGA_ACTIVE     = active_q;
  assign line_start     = line_start_q;
  assign frame_start    = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen.
// One instance uses the default 1280x1024 timing, for the line-level corners.
// A second instance uses a tiny raster with inverted sync polarity, so that
// frame wraps and the frame_count roll-over are reached quickly. Both
// instances share reset and pix_ce. A behavioural model predicts every
// cycle through a scoreboard queue.
module tb_vga_timing_gen;

`ifdef VGA_FRAME_COUNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  // Big (default) timing
  localparam int BHA = 1280, BHF = 48, BHS = 112, BHB = 248;
  localparam int BVA = 1024, BVF = 1,  BVS = 3,   BVB = 38;
  localparam int BHT = BHA + BHF + BHS + BHB;
  localparam int BVT = BVA + BVF + BVS + BVB;
  // Tiny timing, active-low sync
  localparam int SHA = 4, SHF = 1, SHS = 2, SHB = 1;
  localparam int SVA = 2, SVF = 1, SVS = 1, SVB = 1;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;

  typedef struct packed {
    logic [11:0] h;
    logic [11:0] v;
    logic        hs;
    logic        vs;
    logic        act;
    logic        ls;
    logic        fs;
    logic [9:0]  fc;
  } obs_t;

  typedef struct {
    bit rst;
    bit ce;
    int h;
    int v;
    bit hs;
    bit vs;
    bit act;
    bit ls;
    bit fs;
  } vec_t;

  logic        clk_vga;
  logic        reset;
  logic        pix_ce;
  logic [11:0] b_h, b_v, s_h, s_v;
  logic        b_hs, b_vs, b_act, b_ls, b_fs;
  logic        s_hs, s_vs, s_act, s_ls, s_fs;
  logic [9:0]  b_fc, s_fc;
  obs_t        b_obs, s_obs;

  int vectors = 0;
  int miscompares = 0;

  // Model state
  int bh = 0, bv = 0, bfc = 0;
  bit bls = 0, bfs = 0;
  int sh = 0, sv = 0, sfc = 0;
  bit sls = 0, sfs = 0;

  obs_t big_q[$];
  obs_t small_q[$];

  vga_timing_gen u_big (
    .clk_vga(clk_vga), .reset(reset), .pix_ce(pix_ce),
    .VGA_HORZ_COORD(b_h), .VGA_VERT_COORD(b_v),
    .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_ACTIVE(b_act),
    .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SYNC_POL(1'b0)
  ) u_small (
    .clk_vga(clk_vga), .reset(reset), .pix_ce(pix_ce),
    .VGA_HORZ_COORD(s_h), .VGA_VERT_COORD(s_v),
    .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_ACTIVE(s_act),
    .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
  );

  assign b_obs = {b_h, b_v, b_hs, b_vs, b_act, b_ls, b_fs, b_fc};
  assign s_obs = {s_h, s_v, s_hs, s_vs, s_act, s_ls, s_fs, s_fc};

  initial begin
    clk_vga = 1'b0;
    forever #5 clk_vga = ~clk_vga;
  end

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got h=%0d v=%0d hs=%b vs=%b act=%b ls=%b fs=%b fc=%0d, expected h=%0d v=%0d hs=%b vs=%b act=%b ls=%b fs=%b fc=%0d (t=%0t)",
               name, act.h, act.v, act.hs, act.vs, act.act, act.ls, act.fs, act.fc,
               exp.h, exp.v, exp.hs, exp.vs, exp.act, exp.ls, exp.fs, exp.fc, $time);
    end
  endtask

  // Behavioural raster model: advance by one clock edge.
  function automatic void adv(input bit rst, input bit ce, input int ht, input int vt,
                              inout int h, inout int v, inout int fc,
                              inout bit ls, inout bit fs);
    if (rst) begin
      h = 0; v = 0; fc = 0; ls = 1'b0; fs = 1'b0;
    end else if (ce) begin
      ls = (h == ht - 1);
      fs = ls && (v == vt - 1);
      h  = ls ? 0 : h + 1;
      if (ls) v = fs ? 0 : v + 1;
      if (fs) fc = (fc + 1) % 1024;
    end else begin
      ls = 1'b0; fs = 1'b0;
    end
  endfunction

  function automatic obs_t predict(input int h, input int v, input int fc,
                                   input bit ls, input bit fs,
                                   input int ha, input int hfp, input int hsy,
                                   input int va, input int vfp, input int vsy,
                                   input bit pol);
    obs_t o;
    o.h   = h[11:0];
    o.v   = v[11:0];
    o.hs  = (h >= ha + hfp && h < ha + hfp + hsy) ? pol : ~pol;
    o.vs  = (v >= va + vfp && v < va + vfp + vsy) ? pol : ~pol;
    o.act = (h < ha) && (v < va);
    o.ls  = ls;
    o.fs  = fs;
    o.fc  = FC_EN ? fc[9:0] : 10'd0;
    return o;
  endfunction

  // Drive one cycle, queue the predictions, then compare after the edge.
  task automatic step(input bit rst, input bit ce);
    obs_t e;
    reset  = rst;
    pix_ce = ce;
    adv(rst, ce, BHT, BVT, bh, bv, bfc, bls, bfs);
    big_q.push_back(predict(bh, bv, bfc, bls, bfs, BHA, BHF, BHS, BVA, BVF, BVS, 1'b1));
    adv(rst, ce, SHT, SVT, sh, sv, sfc, sls, sfs);
    small_q.push_back(predict(sh, sv, sfc, sls, sfs, SHA, SHF, SHS, SVA, SVF, SVS, 1'b0));
    @(posedge clk_vga);
    #1;
    e = big_q.pop_front();
    check_obs("big_cycle", b_obs, e);
    e = small_q.pop_front();
    check_obs("small_cycle", s_obs, e);
    if (miscompares >= 100) finish_run();
  endtask

  task automatic run_to(input int th, input int tv);
    int n = 0;
    while (!(bh == th && bv == tv) && n < 60000) begin
      step(1'b0, 1'b1);
      n++;
    end
    if (n >= 60000) check("run_to_bound", n, 0);
  endtask

  task automatic run_small_to(input int th, input int tv);
    int n = 0;
    while (!(sh == th && sv == tv) && n < 200) begin
      step(1'b0, 1'b1);
      n++;
    end
    if (n >= 200) check("run_small_to_bound", n, 0);
  endtask

  initial begin
    vec_t tbl[8];
    int   cnt;

    reset  = 1'b1;
    pix_ce = 1'b1;

    // Reset held for three cycles with pix_ce=1, release, then pix_ce 1,0,0,1.
    tbl[0] = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 2, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 2, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 2, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 3, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].rst, tbl[i].ce);
      check("tbl_h",   32'(b_h),   tbl[i].h);
      check("tbl_v",   32'(b_v),   tbl[i].v);
      check("tbl_hs",  32'(b_hs),  32'(tbl[i].hs));
      check("tbl_vs",  32'(b_vs),  32'(tbl[i].vs));
      check("tbl_act", 32'(b_act), 32'(tbl[i].act));
      check("tbl_ls",  32'(b_ls),  32'(tbl[i].ls));
      check("tbl_fs",  32'(b_fs),  32'(tbl[i].fs));
      check("tbl_fc",  32'(b_fc),  0);
    end

    // CE gating from h=100: 1,0,0,1 gives 101,101,101,102 with no strobes.
    run_to(100, 0);
    step(1'b0, 1'b1); check("ce_h_101a", 32'(b_h), 101);
    step(1'b0, 1'b0); check("ce_h_101b", 32'(b_h), 101); check("ce_ls_b", 32'(b_ls), 0);
    step(1'b0, 1'b0); check("ce_h_101c", 32'(b_h), 101); check("ce_ls_c", 32'(b_ls), 0);
    step(1'b0, 1'b1); check("ce_h_102",  32'(b_h), 102); check("ce_ls_d", 32'(b_ls), 0);

    // Active-area edge and the HS pulse.
    run_to(1279, 0);
    check("act_1279", 32'(b_act), 1);
    step(1'b0, 1'b1);
    check("act_1280", 32'(b_act), 0);
    run_to(1327, 0);
    check("hs_1327", 32'(b_hs), 0);
    step(1'b0, 1'b1);
    check("hs_1328", 32'(b_hs), 1);
    cnt = 1;
    for (int i = 0; i < 111; i++) begin
      step(1'b0, 1'b1);
      if (b_hs === 1'b1) cnt++;
    end
    check("hs_h_1439", 32'(b_h), 1439);
    step(1'b0, 1'b1);
    check("hs_1440", 32'(b_hs), 0);
    check("hs_width", cnt, 112);

    // Line wrap at (1687,5).
    run_to(1687, 5);
    check("lw_act_1687", 32'(b_act), 0);
    step(1'b0, 1'b1);
    check("lw_h", 32'(b_h), 0);
    check("lw_v", 32'(b_v), 6);
    check("lw_ls", 32'(b_ls), 1);
    check("lw_fs", 32'(b_fs), 0);
    step(1'b0, 1'b1);
    check("lw_ls_drop", 32'(b_ls), 0);

    // Mid-frame reset, then release with no strobe.
    run_to(500, 6);
    step(1'b1, 1'b1);
    check("mr_h", 32'(b_h), 0);
    check("mr_v", 32'(b_v), 0);
    check("mr_fc", 32'(b_fc), 0);
    check("mr_hs", 32'(b_hs), 0);
    check("mr_small_hs", 32'(s_hs), 1);
    step(1'b0, 1'b1);
    check("mr_exit_h", 32'(b_h), 1);
    check("mr_exit_ls", 32'(b_ls), 0);
    check("mr_exit_fs", 32'(b_fs), 0);

    // Frame wrap on the tiny raster.
    run_small_to(SHT - 1, SVT - 1);
    step(1'b0, 1'b1);
    check("fw_h", 32'(s_h), 0);
    check("fw_v", 32'(s_v), 0);
    check("fw_fs", 32'(s_fs), 1);
    check("fw_ls", 32'(s_ls), 1);
    check("fw_fc", 32'(s_fc), FC_EN ? 1 : 0);
    cnt = 0;
    for (int i = 0; i < SHT * SVT; i++) begin
      step(1'b0, 1'b1);
      if (s_vs === 1'b0) cnt++;
      if (i == 0) check("fw_fs_drop", 32'(s_fs), 0);
    end
    check("vs_width", cnt, SVS * SHT);

    // frame_count roll-over 1023 -> 0.
    cnt = 0;
    while (sfc != 1023 && cnt < 60000) begin
      step(1'b0, 1'b1);
      cnt++;
    end
    if (cnt >= 60000) check("fc_run_bound", cnt, 0);
    check("fc_1023", 32'(s_fc), FC_EN ? 1023 : 0);
    run_small_to(SHT - 1, SVT - 1);
    step(1'b0, 1'b1);
    check("fc_wrap", 32'(s_fc), 0);
    check("fc_wrap_fs", 32'(s_fs), 1);

    finish_run();
  end

endmodule
